// File: rtl/a2d_seq.sv
// Round-robin A2D conversion sequencer driving an SPI master over four channels.
// Optional A2D_SEQ_AVG_EN build averages each new sample with the previous one.
module a2d_seq #(
    parameter logic [2:0] CH_LFT   = 3'd0,
    parameter logic [2:0] CH_RGHT  = 3'd4,
    parameter logic [2:0] CH_STEER = 3'd5,
    parameter logic [2:0] CH_BATT  = 3'd6,
    parameter int         GAP      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] wt_data,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt,
    output logic        busy,
    output logic        rnd_done
);

    localparam int GW = (GAP < 2) ? 1 : $clog2(GAP + 1);

    typedef enum logic [2:0] {
        IDLE, CMD, WAIT1, GAP1, RD, WAIT2
    } state_t;

    state_t        state;
    logic [1:0]    idx;
    logic [GW-1:0] gap_cnt;
    logic          to_rd;
    logic [2:0]    ch_cur;
    logic [15:0]   cmd;
    logic [11:0]   cap_val;
    logic          unused_rd;

    assign unused_rd = ^rd_data[15:12];

    always_comb begin
        ch_cur = CH_LFT;
        case (idx)
            2'd0: ch_cur = CH_LFT;
            2'd1: ch_cur = CH_RGHT;
            2'd2: ch_cur = CH_STEER;
            2'd3: ch_cur = CH_BATT;
            default: ch_cur = CH_LFT;
        endcase
    end

    assign cmd = {2'b00, ch_cur, 11'h000};

`ifdef A2D_SEQ_AVG_EN
    logic [3:0]  seen;
    logic [11:0] old_val;
    logic [12:0] sum;

    always_comb begin
        old_val = lft_ld;
        case (idx)
            2'd0: old_val = lft_ld;
            2'd1: old_val = rght_ld;
            2'd2: old_val = steer_pot;
            2'd3: old_val = batt;
            default: old_val = lft_ld;
        endcase
    end

    // First sample after reset has no history, so it is stored raw
    assign sum     = {1'b0, old_val} + {1'b0, rd_data[11:0]} + 13'd1;
    assign cap_val = seen[idx] ? sum[12:1] : rd_data[11:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            seen <= '0;
        else if (state == WAIT2 && done)
            seen[idx] <= 1'b1;
    end
`else
    assign cap_val = rd_data[11:0];
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            idx       <= '0;
            gap_cnt   <= '0;
            to_rd     <= 1'b0;
            wrt       <= 1'b0;
            wt_data   <= '0;
            busy      <= 1'b0;
            rnd_done  <= 1'b0;
            lft_ld    <= '0;
            rght_ld   <= '0;
            steer_pot <= '0;
            batt      <= '0;
        end else begin
            wrt      <= 1'b0;
            rnd_done <= 1'b0;
            case (state)
                IDLE: begin
                    // nxt landing on the rnd_done cycle is dropped
                    if (nxt && !rnd_done) begin
                        state   <= CMD;
                        busy    <= 1'b1;
                        wrt     <= 1'b1;
                        wt_data <= cmd;
                    end
                end
                CMD: state <= WAIT1;
                WAIT1: begin
                    if (done) begin
                        gap_cnt <= GW'(GAP);
                        to_rd   <= 1'b1;
                        state   <= GAP1;
                    end
                end
                GAP1: begin
                    if (gap_cnt <= GW'(1)) begin
                        gap_cnt <= '0;
                        wrt     <= 1'b1;
                        wt_data <= cmd;
                        state   <= to_rd ? RD : CMD;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                    end
                end
                RD: state <= WAIT2;
                WAIT2: begin
                    if (done) begin
                        case (idx)
                            2'd0: lft_ld    <= cap_val;
                            2'd1: rght_ld   <= cap_val;
                            2'd2: steer_pot <= cap_val;
                            2'd3: batt      <= cap_val;
                            default: ;
                        endcase
                        if (idx == 2'd3) begin
                            idx      <= '0;
                            busy     <= 1'b0;
                            rnd_done <= 1'b1;
                            state    <= IDLE;
                        end else begin
                            idx     <= idx + 2'd1;
                            gap_cnt <= GW'(GAP);
                            to_rd   <= 1'b0;
                            state   <= GAP1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_a2d_seq.sv
// Randomized bench for a2d_seq with an SPI responder and a per-round result model.
// Define A2D_SEQ_AVG_EN for both bench and RTL to exercise the averaging build.
module tb_a2d_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        nxt = 1'b0;
    logic        wrt;
    logic [15:0] wt_data;
    logic        done;
    logic        done_resp = 1'b0;
    logic        force_done = 1'b0;
    logic [15:0] rd_data = '0;
    logic [11:0] lft_ld, rght_ld, steer_pot, batt;
    logic        busy, rnd_done;

    always #5 clk = ~clk;

    assign done = done_resp | force_done;

    a2d_seq dut (
        .clk(clk), .rst(rst), .nxt(nxt), .wrt(wrt), .wt_data(wt_data),
        .done(done), .rd_data(rd_data), .lft_ld(lft_ld), .rght_ld(rght_ld),
        .steer_pot(steer_pot), .batt(batt), .busy(busy), .rnd_done(rnd_done)
    );

    logic [11:0] res[4];
    assign res[0] = lft_ld;
    assign res[1] = rght_ld;
    assign res[2] = steer_pot;
    assign res[3] = batt;

    int total = 0;
    int bad = 0;

    // Stimulus values returned on each channel's second transaction, and model
    logic [11:0] val[4];
    logic [11:0] expv[4];
    bit          seen_m[4];
    int          rst_gen = 0;
    logic [15:0] exp_cmd[4] = '{16'h0000, 16'h2000, 16'h2800, 16'h3000};

    function automatic int ch_idx(input logic [2:0] c);
        case (c)
            3'd0: return 0;
            3'd4: return 1;
            3'd5: return 2;
            default: return 3;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            expv[i] = '0;
            seen_m[i] = 0;
        end
    endtask

    task automatic model_round();
        for (int i = 0; i < 4; i++) begin
`ifdef A2D_SEQ_AVG_EN
            if (seen_m[i])
                expv[i] = 12'((13'(expv[i]) + 13'(val[i]) + 13'd1) >> 1);
            else
                expv[i] = val[i];
`else
            expv[i] = val[i];
`endif
            seen_m[i] = 1;
        end
    endtask

    // SPI master model: first transaction of a pair returns junk
    bit second = 0;
    int seen_gen = 0;
    always begin : spi
        int lat, g, k;
        logic [15:0] w;
        @(posedge clk);
        #1;
        if (seen_gen != rst_gen) begin
            second = 0;
            seen_gen = rst_gen;
        end
        if (!rst && wrt) begin
            g = rst_gen;
            w = wt_data;
            lat = $urandom_range(1, 4);
            repeat (lat) @(posedge clk);
            #1;
            if (g == rst_gen && !rst) begin
                k = ch_idx(w[13:11]);
                rd_data = second ? {4'($urandom), val[k]} : 16'($urandom);
                done_resp = 1'b1;
                @(posedge clk);
                #1;
                done_resp = 1'b0;
                second = !second;
            end
        end
    end

    // Bus monitor
    int          wrt_cnt = 0, rnd_cnt = 0, bfall = 0;
    int          consec_err = 0, stab_err = 0;
    logic [15:0] wq[$];
    int          gaps[$];
    logic [15:0] last_wd = '0;
    bit          prev_wrt = 0, prev_busy = 0, pend = 0;
    int          gcnt = 0;

    always @(negedge clk) begin
        if (pend) begin
            gcnt++;
            if (wrt) begin
                gaps.push_back(gcnt);
                pend = 0;
            end else if (!busy) begin
                pend = 0;
            end
        end
        if (done_resp && busy) begin
            pend = 1;
            gcnt = 0;
        end
        if (wrt) begin
            wrt_cnt++;
            wq.push_back(wt_data);
            last_wd = wt_data;
        end
        if (prev_wrt && wrt) consec_err++;
        if (busy && !wrt && wt_data !== last_wd) stab_err++;
        if (rnd_done) rnd_cnt++;
        if (prev_busy && !busy) bfall++;
        prev_wrt = wrt;
        prev_busy = busy;
    end

    task automatic start_round(output bit busy_now);
        @(posedge clk);
        #1;
        nxt = 1'b1;
        @(posedge clk);
        #1;
        nxt = 1'b0;
        busy_now = busy;
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (rnd_done) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rst_gen++;
        model_reset();
        #2;
        total++;
        if ({wrt, busy, rnd_done} !== 3'b000) begin
            bad++;
            $display("FAIL reset_ctl: got %b want 000", {wrt, busy, rnd_done});
        end
        total++;
        if (wt_data !== 16'h0000) begin
            bad++;
            $display("FAIL reset_wt_data: got %h want 0000", wt_data);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (res[i] !== 12'h000) begin
                bad++;
                $display("FAIL reset_res%0d: got %h want 000", i, res[i]);
            end
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
    endtask

    task automatic test_round(input logic [11:0] v0, v1, v2, v3,
                              input bit full);
        bit bo, ok;
        int w0, r0, q0, g0;
        val[0] = v0; val[1] = v1; val[2] = v2; val[3] = v3;
        w0 = wrt_cnt; r0 = rnd_cnt; q0 = wq.size(); g0 = gaps.size();
        start_round(bo);
        total++;
        if (bo !== 1'b1) begin
            bad++;
            $display("FAIL busy_rise: got %b want 1", bo);
        end
        wait_done(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL round_timeout: got 0 want 1");
        end
        @(posedge clk);
        #1;
        model_round();
        for (int i = 0; i < 4; i++) begin
            total++;
            if (res[i] !== expv[i]) begin
                bad++;
                $display("FAIL result%0d: got %h want %h", i, res[i], expv[i]);
            end
        end
        if (full) begin
            total++;
            if (wrt_cnt - w0 != 8 || rnd_cnt - r0 != 1) begin
                bad++;
                $display("FAIL pulse_counts: wrt %0d rnd %0d want 8 1",
                         wrt_cnt - w0, rnd_cnt - r0);
            end
            for (int i = 0; i < 8; i++) begin
                total++;
                if (q0 + i >= wq.size() || wq[q0 + i] !== exp_cmd[i / 2]) begin
                    bad++;
                    $display("FAIL wt_data%0d: got %h want %h", i,
                             (q0 + i < wq.size()) ? wq[q0 + i] : 16'hxxxx,
                             exp_cmd[i / 2]);
                end
            end
            total++;
            if (gaps.size() - g0 != 7) begin
                bad++;
                $display("FAIL gap_count: got %0d want 7", gaps.size() - g0);
            end
            for (int i = g0; i < gaps.size(); i++) begin
                total++;
                if (gaps[i] != 3) begin
                    bad++;
                    $display("FAIL done_to_wrt: got %0d want 3", gaps[i]);
                end
            end
        end
    endtask

    task automatic test_random_rounds();
        for (int n = 0; n < 4; n++)
            test_round(12'($urandom), 12'($urandom), 12'($urandom),
                       12'($urandom), 0);
    endtask

    task automatic test_nxt_ignore();
        bit bo, ok;
        int w0, b0;
        val[0] = 12'h111; val[1] = 12'h222; val[2] = 12'h333; val[3] = 12'h444;
        w0 = wrt_cnt; b0 = bfall;
        start_round(bo);
        for (int n = 0; n < 5; n++) begin
            repeat ($urandom_range(1, 6)) @(posedge clk);
            #1;
            total++;
            if (busy !== 1'b1) begin
                bad++;
                $display("FAIL busy_hold%0d: got %b want 1", n, busy);
            end
            nxt = 1'b1;
            @(posedge clk);
            #1;
            nxt = 1'b0;
        end
        wait_done(ok);
        // nxt coincident with rnd_done must not start a round
        nxt = 1'b1;
        @(posedge clk);
        #1;
        nxt = 1'b0;
        repeat (20) @(posedge clk);
        #1;
        model_round();
        total++;
        if (!ok || wrt_cnt - w0 != 8) begin
            bad++;
            $display("FAIL nxt_ignore_wrt: got %0d want 8", wrt_cnt - w0);
        end
        total++;
        if (bfall - b0 != 1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL nxt_ignore_busy: falls %0d busy %b want 1 0",
                     bfall - b0, busy);
        end
        total++;
        if (res[3] !== expv[3]) begin
            bad++;
            $display("FAIL nxt_ignore_batt: got %h want %h", res[3], expv[3]);
        end
    endtask

    task automatic test_reset_mid();
        bit bo, ok;
        int w0, r0, q0;
        val[0] = 12'h5a5; val[1] = 12'h3c3; val[2] = 12'h777; val[3] = 12'h999;
        w0 = wrt_cnt; r0 = rnd_cnt;
        start_round(bo);
        ok = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (wrt_cnt - w0 == 6) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        total++;
        if (!ok || lft_ld !== val[0]) begin
            bad++;
            $display("FAIL mid_pre: got %h want %h", lft_ld, val[0]);
        end
        rst = 1'b1;
        rst_gen++;
        model_reset();
        #1;
        total++;
        if ({busy, wrt, rnd_done} !== 3'b000 || wt_data !== 16'h0 ||
            {lft_ld, rght_ld, steer_pot, batt} !== 48'h0) begin
            bad++;
            $display("FAIL mid_reset: got busy %b res %h %h %h %h want 0",
                     busy, lft_ld, rght_ld, steer_pot, batt);
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (rnd_cnt != r0 || wrt_cnt - w0 != 6) begin
            bad++;
            $display("FAIL mid_no_rnd: rnd %0d wrt %0d want 0 6",
                     rnd_cnt - r0, wrt_cnt - w0);
        end
        q0 = wq.size();
        test_round(12'h0a1, 12'h0b2, 12'h0c3, 12'h0d4, 1);
        total++;
        if (q0 >= wq.size() || wq[q0] !== 16'h0000) begin
            bad++;
            $display("FAIL mid_restart: got %h want 0000",
                     (q0 < wq.size()) ? wq[q0] : 16'hxxxx);
        end
    endtask

    task automatic test_spurious_done();
        bit bo, ok;
        int w0;
        w0 = wrt_cnt;
        @(posedge clk);
        #1;
        force_done = 1'b1;
        @(posedge clk);
        #1;
        force_done = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (wrt_cnt != w0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL idle_done: wrt %0d busy %b want 0 0",
                     wrt_cnt - w0, busy);
        end
        val[0] = 12'h123; val[1] = 12'h456; val[2] = 12'h789; val[3] = 12'habc;
        start_round(bo);
        ok = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done_resp) begin
                ok = 1;
                break;
            end
        end
        @(posedge clk);
        #1;
        force_done = 1'b1;
        @(posedge clk);
        #1;
        force_done = 1'b0;
        wait_done(ok);
        @(posedge clk);
        #1;
        model_round();
        total++;
        if (!ok || wrt_cnt - w0 != 8) begin
            bad++;
            $display("FAIL gap_done_wrt: got %0d want 8", wrt_cnt - w0);
        end
        for (int i = 0; i < 4; i++) begin
            total++;
            if (res[i] !== expv[i]) begin
                bad++;
                $display("FAIL gap_done_res%0d: got %h want %h",
                         i, res[i], expv[i]);
            end
        end
        total++;
        if (consec_err != 0 || stab_err != 0) begin
            bad++;
            $display("FAIL wrt_rules: consec %0d unstable %0d want 0 0",
                     consec_err, stab_err);
        end
    endtask

    task automatic test_avg();
        logic [11:0] want;
        test_reset();
        test_round(12'h100, 12'h010, 12'h020, 12'h030, 0);
        total++;
        if (lft_ld !== 12'h100) begin
            bad++;
            $display("FAIL avg_first: got %h want 100", lft_ld);
        end
        test_round(12'h201, 12'h011, 12'h021, 12'h031, 0);
`ifdef A2D_SEQ_AVG_EN
        want = 12'h181;
`else
        want = 12'h201;
`endif
        total++;
        if (lft_ld !== want) begin
            bad++;
            $display("FAIL avg_second: got %h want %h", lft_ld, want);
        end
    endtask

    initial begin
        test_reset();
        test_round(12'h300, 12'h300, 12'h800, 12'hC00, 1);
        test_random_rounds();
        test_nxt_ignore();
        test_reset_mid();
        test_spurious_done();
        test_avg();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
